// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module  : serial_add_pkg
// Brief   : Shared state encoding and counter sizing for the bit-serial adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-index counter must reach WIDTH-1 with headroom.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fa_cell.sv
// ============================================================================
// Module  : fa_cell
// Brief   : One-bit full adder from two half adders and an OR for the carry.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  ha u_ha0 (
    .i_a (i_a),
    .i_b (i_b),
    .o_s (w_s0),
    .o_c (w_c0)
  );

  ha u_ha1 (
    .i_a (w_s0),
    .i_b (i_ci),
    .o_s (o_s),
    .o_c (w_c1)
  );

  assign o_co = w_c0 | w_c1;

endmodule

`default_nettype wire

// File: rtl/ha.sv
// ============================================================================
// Module  : ha
// Brief   : One-bit half adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ha (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module  : serial_add_ctrl
// Brief   : Bit-serial adder controller, LSB first, one fa_cell, start/ready
//           and valid/ack handshakes. SERIAL_ADD_SUB_EN adds sub/ovf ports.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             ready,
  output logic             busy,
  output logic             valid,
  input  logic             ack,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_op_b_ld;
  logic             w_cin_ld;

  fa_cell u_fa (
    .i_a  (r_op_a[0]),
    .i_b  (r_op_b[0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  logic r_ovf;
  // Subtraction is a + ~b + 1; the caller's cin is irrelevant then.
  assign w_op_b_ld = sub ? ~b : b;
  assign w_cin_ld  = sub ? 1'b1 : cin;
  assign ovf       = r_ovf;
`else
  assign w_op_b_ld = b;
  assign w_cin_ld  = cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    busy   = 1'b0;
    valid  = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        valid = 1'b1;
        if (ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op_a  <= a;
            r_op_b  <= w_op_b_ld;
            r_carry <= w_cin_ld;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_op_a  <= r_op_a >> 1;
          r_op_b  <= r_op_b >> 1;
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_carry <= w_co;
          r_cnt   <= r_cnt + CNT_W'(1);
          // Result carry is captured separately so the next accept cannot disturb it.
          if (w_last) begin
            r_cout <= w_co;
`ifdef SERIAL_ADD_SUB_EN
            r_ovf  <= r_carry ^ w_co;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module  : tb_serial_add_ctrl
// Brief   : Directed self-checking bench for serial_add_ctrl (WIDTH=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       ack = 1'b0;
  logic       ready;
  logic       busy;
  logic       valid;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub = 1'b0;
  logic       ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
    .ovf   (ovf),
`endif
    .ready (ready),
    .busy  (busy),
    .valid (valid),
    .ack   (ack),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tc, input logic ts);
    a   = ta;
    b   = tb_v;
    cin = tc;
`ifdef SERIAL_ADD_SUB_EN
    sub = ts;
`else
    if (ts) a = ta;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (busy  !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (sum !== 8'h00)  begin errors++; $display("FAIL reset_sum got=%h exp=00", sum); end
    checks++; if (cout !== 1'b0)  begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
`ifdef SERIAL_ADD_SUB_EN
    checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int n;
    launch(8'h5A, 8'h33, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL basic_busy got busy=%b ready=%b exp busy=1 ready=0", busy, ready); end
    wait_valid(n);
    checks++; if (n != 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", n); end
    checks++; if (sum !== 8'h8D) begin errors++; $display("FAIL basic_sum got=%h exp=8d", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL basic_cout got=%b exp=0", cout); end
    checks++; if (ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_onehot got ready=%b busy=%b exp 0 0", ready, busy); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (ready !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL basic_ack got ready=%b valid=%b exp 1 0", ready, valid); end
    checks++; if (sum !== 8'h8D) begin errors++; $display("FAIL basic_idle_hold got=%h exp=8d", sum); end
  endtask

  task automatic test_carry;
    int n;
    ack = 1'b1;  // held through RUN; must be ignored there
    launch(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_valid(n);
    ack = 1'b0;
    checks++; if (n != 8) begin errors++; $display("FAIL carry1_latency got=%0d exp=8", n); end
    checks++; if ({cout, sum} !== 9'h100) begin errors++; $display("FAIL carry1_result got=%b_%h exp=1_00", cout, sum); end
    ack = 1'b1; tick(); ack = 1'b0;
    launch(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_valid(n);
    checks++; if ({cout, sum} !== 9'h1FF) begin errors++; $display("FAIL carry2_result got=%b_%h exp=1_ff", cout, sum); end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_ignore_start;
    int n;
    launch(8'h5A, 8'h33, 1'b0, 1'b0);
    a = 8'h00; b = 8'h00; start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    wait_valid(n);
    checks++; if (n != 5) begin errors++; $display("FAIL ign_latency got=%0d exp=5", n); end
    checks++; if ({cout, sum} !== 9'h08D) begin errors++; $display("FAIL ign_result got=%b_%h exp=0_8d", cout, sum); end
    a = 8'h77; b = 8'h11; start = 1'b1; ack = 1'b1;
    tick();
    start = 1'b0; ack = 1'b0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL startack_idle got ready=%b busy=%b exp 1 0", ready, busy); end
    tick();
    checks++; if (ready !== 1'b1 || sum !== 8'h8D) begin errors++; $display("FAIL startack_noop got ready=%b sum=%h exp 1 8d", ready, sum); end
  endtask

  task automatic test_mid_reset;
    int n;
    launch(8'h5A, 8'h33, 1'b0, 1'b0);
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL midrst_flags got r=%b b=%b v=%b exp 1 0 0", ready, busy, valid); end
    checks++; if (sum !== 8'h00 || cout !== 1'b0) begin errors++; $display("FAIL midrst_result got=%b_%h exp=0_00", cout, sum); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    launch(8'h12, 8'h34, 1'b0, 1'b0);
    wait_valid(n);
    checks++; if (n != 8 || {cout, sum} !== 9'h046) begin errors++; $display("FAIL midrst_new got n=%0d %b_%h exp 8 0_46", n, cout, sum); end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_hold;
    int n;
    launch(8'hC8, 8'h64, 1'b1, 1'b0);  // 200+100+1 = 301 = 0x12D
    wait_valid(n);
    checks++; if ({cout, sum} !== 9'h12D) begin errors++; $display("FAIL hold_result got=%b_%h exp=1_2d", cout, sum); end
    for (int i = 0; i < 20; i++) begin
      a = ~a; b = b + 8'h17; cin = ~cin;
      tick();
      checks++;
      if (valid !== 1'b1 || {cout, sum} !== 9'h12D) begin
        errors++;
        $display("FAIL hold_cycle%0d got v=%b %b_%h exp 1 1_2d", i, valid, cout, sum);
      end
    end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL hold_ack got ready=%b exp=1", ready); end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    int n;
    launch(8'h10, 8'h20, 1'b1, 1'b1);  // cin must be ignored
    wait_valid(n);
    checks++; if ({cout, sum} !== 9'h0F0 || ovf !== 1'b0) begin errors++; $display("FAIL sub1 got %b_%h ovf=%b exp 0_f0 ovf=0", cout, sum, ovf); end
    ack = 1'b1; tick(); ack = 1'b0;
    launch(8'h80, 8'h01, 1'b0, 1'b1);
    wait_valid(n);
    checks++; if ({cout, sum} !== 9'h17F || ovf !== 1'b1) begin errors++; $display("FAIL sub2 got %b_%h ovf=%b exp 1_7f ovf=1", cout, sum, ovf); end
    ack = 1'b1; tick(); ack = 1'b0;
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_mid_reset();
    test_hold();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
